id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register and operand-forwarding stage that feeds the 64-bit ALU.

---
 rtl/id_ex_operand_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_operand_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use stall detection.
// Optional IDEX_PERF_CNT_EN adds stall/flush event counters (perf_stall_cnt, perf_flush_cnt).
module id_ex_operand_stage #(
   parameter int DW  = 64,
   parameter int RW  = 5,
   parameter int XZR = 31
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic [DW-1:0] id_a,
   input  logic [DW-1:0] id_b,
   input  logic [DW-1:0] id_imm,
   input  logic [RW-1:0] id_rn,
   input  logic [RW-1:0] id_rm,
   input  logic [RW-1:0] id_rd,
   input  logic          id_alusrc,
   input  logic [3:0]    id_aluctr,
   input  logic [3:0]    id_ctrl,
   input  logic          hold,
   input  logic          flush,
   input  logic          mem_regwrite,
   input  logic [RW-1:0] mem_rd,
   input  logic [DW-1:0] mem_result,
   input  logic          wb_regwrite,
   input  logic [RW-1:0] wb_rd,
   input  logic [DW-1:0] wb_result,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [3:0]    alu_ctr,
   output logic          ex_valid,
   output logic [RW-1:0] ex_rd,
   output logic [3:0]    ex_ctrl,
   output logic [DW-1:0] ex_store_data,
   output logic          stall_o
`ifdef IDEX_PERF_CNT_EN
   ,
   output logic [31:0]   perf_stall_cnt,
   output logic [31:0]   perf_flush_cnt
`endif
);

   localparam logic [RW-1:0] XzrIdx = RW'(XZR);

   typedef struct packed {
      logic          valid;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] imm;
      logic [RW-1:0] rn;
      logic [RW-1:0] rm;
      logic [RW-1:0] rd;
      logic          alusrc;
      logic [3:0]    aluctr;
      logic [3:0]    ctrl;
   } stage_t;

   stage_t stage_d, stage_q;
   logic [DW-1:0] fwd_rn, fwd_rm;

   // ctrl bit 2 is MemRead: a load in EX whose target is read by ID must wait one cycle
   assign stall_o = stage_q.valid & stage_q.ctrl[2] & id_valid & (stage_q.rd != XzrIdx) &
                    ((stage_q.rd == id_rn) | (stage_q.rd == id_rm));

   always_comb begin
      stage_d = stage_q;
      if (!hold) begin
         if (flush || stall_o) begin
            stage_d.valid = 1'b0;
            stage_d.ctrl  = 4'd0;
         end else begin
            stage_d.valid  = id_valid;
            stage_d.a      = id_a;
            stage_d.b      = id_b;
            stage_d.imm    = id_imm;
            stage_d.rn     = id_rn;
            stage_d.rm     = id_rm;
            stage_d.rd     = id_rd;
            stage_d.alusrc = id_alusrc;
            stage_d.aluctr = id_aluctr;
            stage_d.ctrl   = id_valid ? id_ctrl : 4'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   // Forwarding is suppressed for an empty stage so a freshly reset stage presents zero operands
   always_comb begin
      fwd_rn = stage_q.a;
      fwd_rm = stage_q.b;
      if (stage_q.valid && stage_q.rn != XzrIdx) begin
         if (mem_regwrite && mem_rd == stage_q.rn) begin
            fwd_rn = mem_result;
         end else if (wb_regwrite && wb_rd == stage_q.rn) begin
            fwd_rn = wb_result;
         end
      end
      if (stage_q.valid && stage_q.rm != XzrIdx) begin
         if (mem_regwrite && mem_rd == stage_q.rm) begin
            fwd_rm = mem_result;
         end else if (wb_regwrite && wb_rd == stage_q.rm) begin
            fwd_rm = wb_result;
         end
      end
   end

   assign alu_a         = fwd_rn;
   assign alu_b         = stage_q.alusrc ? stage_q.imm : fwd_rm;
   assign ex_store_data = fwd_rm;
   assign alu_ctr       = stage_q.aluctr;
   assign ex_valid      = stage_q.valid;
   assign ex_rd         = stage_q.rd;
   assign ex_ctrl       = stage_q.ctrl;

`ifdef IDEX_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else if (!hold) begin
         if (stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (flush)   flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: vector table plus hand sequences for reset, hold/flush and load-use.
// Expected EX-stage results go through a scoreboard queue; perf counters checked when IDEX_PERF_CNT_EN is defined.
module tb_id_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [63:0] id_a, id_b, id_imm;
   logic [4:0]  id_rn, id_rm, id_rd;
   logic        id_alusrc;
   logic [3:0]  id_aluctr, id_ctrl;
   logic        hold, flush;
   logic        mem_regwrite;
   logic [4:0]  mem_rd;
   logic [63:0] mem_result;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [63:0] wb_result;
   logic [63:0] alu_a, alu_b, ex_store_data;
   logic [3:0]  alu_ctr, ex_ctrl;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic        stall_o;
`ifdef IDEX_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   typedef struct {
      logic        valid;
      logic [3:0]  ctrl;
      logic [3:0]  ctr;
      logic [4:0]  rd;
      logic [63:0] aluA;
      logic [63:0] aluB;
      logic [63:0] st;
   } expect_t;

   typedef struct {
      logic        idValid;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] imm;
      logic [4:0]  rn;
      logic [4:0]  rm;
      logic [4:0]  rd;
      logic        alusrc;
      logic [3:0]  ctr;
      logic [3:0]  ctrl;
      logic        memRw;
      logic [4:0]  memRd;
      logic [63:0] memRes;
      logic        wbRw;
      logic [4:0]  wbRd;
      logic [63:0] wbRes;
      expect_t     exp;
   } vec_t;

   expect_t scoreboard[$];
   vec_t    vecs[9];
   int      checks = 0;
   int      errors = 0;
   int      expStallCnt = 0;
   int      expFlushCnt = 0;

   id_ex_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
      .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
      .id_alusrc(id_alusrc), .id_aluctr(id_aluctr), .id_ctrl(id_ctrl),
      .hold(hold), .flush(flush),
      .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
      .ex_store_data(ex_store_data), .stall_o(stall_o)
`ifdef IDEX_PERF_CNT_EN
      ,
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard stop in case a sequence never returns
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Pops the oldest expected EX state and compares; data fields only matter for a valid instruction
   task automatic checkOutput(input string name);
      expect_t e;
      if (scoreboard.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s actual=empty-scoreboard required=entry", name);
      end else begin
         e = scoreboard.pop_front();
         checkField({name, ".valid"}, {63'd0, ex_valid}, {63'd0, e.valid});
         checkField({name, ".ctrl"}, {60'd0, ex_ctrl}, {60'd0, e.ctrl});
         if (e.valid) begin
            checkField({name, ".ctr"}, {60'd0, alu_ctr}, {60'd0, e.ctr});
            checkField({name, ".rd"}, {59'd0, ex_rd}, {59'd0, e.rd});
            checkField({name, ".aluA"}, alu_a, e.aluA);
            checkField({name, ".aluB"}, alu_b, e.aluB);
            checkField({name, ".st"}, ex_store_data, e.st);
         end
      end
   endtask

   task automatic quietInputs();
      id_valid = 1'b0; id_a = '0; id_b = '0; id_imm = '0;
      id_rn = 5'd0; id_rm = 5'd0; id_rd = 5'd0;
      id_alusrc = 1'b0; id_aluctr = 4'd0; id_ctrl = 4'd0;
      hold = 1'b0; flush = 1'b0;
      mem_regwrite = 1'b0; mem_rd = 5'd0; mem_result = '0;
      wb_regwrite = 1'b0; wb_rd = 5'd0; wb_result = '0;
   endtask

   task automatic randomInputs();
      id_valid = 1'($urandom); id_a = {$urandom, $urandom}; id_b = {$urandom, $urandom};
      id_imm = {$urandom, $urandom}; id_rn = 5'($urandom); id_rm = 5'($urandom);
      id_rd = 5'($urandom); id_alusrc = 1'($urandom); id_aluctr = 4'($urandom);
      id_ctrl = 4'($urandom); hold = 1'($urandom); flush = 1'($urandom);
      mem_regwrite = 1'b1; mem_rd = 5'd0; mem_result = {$urandom, $urandom};
      wb_regwrite = 1'b1; wb_rd = 5'd0; wb_result = {$urandom, $urandom};
   endtask

   task automatic applyStimulus(input vec_t v);
      hold = 1'b0; flush = 1'b0;
      id_valid = v.idValid; id_a = v.a; id_b = v.b; id_imm = v.imm;
      id_rn = v.rn; id_rm = v.rm; id_rd = v.rd;
      id_alusrc = v.alusrc; id_aluctr = v.ctr; id_ctrl = v.ctrl;
      mem_regwrite = v.memRw; mem_rd = v.memRd; mem_result = v.memRes;
      wb_regwrite = v.wbRw; wb_rd = v.wbRd; wb_result = v.wbRes;
      scoreboard.push_back(v.exp);
   endtask

   task automatic driveId(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                          input logic alusrc, input logic [3:0] ctr, input logic [3:0] ctrl);
      id_valid = 1'b1; id_rn = rn; id_rm = rm; id_rd = rd;
      id_a = a; id_b = b; id_imm = imm; id_alusrc = alusrc;
      id_aluctr = ctr; id_ctrl = ctrl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetState(input string name);
      checkField({name, ".valid"}, {63'd0, ex_valid}, 64'd0);
      checkField({name, ".ctrl"}, {60'd0, ex_ctrl}, 64'd0);
      checkField({name, ".ctr"}, {60'd0, alu_ctr}, 64'd0);
      checkField({name, ".rd"}, {59'd0, ex_rd}, 64'd0);
      checkField({name, ".aluA"}, alu_a, 64'd0);
      checkField({name, ".aluB"}, alu_b, 64'd0);
      checkField({name, ".st"}, ex_store_data, 64'd0);
      checkField({name, ".stall"}, {63'd0, stall_o}, 64'd0);
   endtask

   task automatic checkPerf(input string name);
`ifdef IDEX_PERF_CNT_EN
      checkField({name, ".stallCnt"}, {32'd0, perf_stall_cnt}, 64'(expStallCnt));
      checkField({name, ".flushCnt"}, {32'd0, perf_flush_cnt}, 64'(expFlushCnt));
`else
      if (name.len() == 0) $display("[TB] unnamed perf check");
`endif
   endtask

   initial begin
      expect_t frozen;

      // idValid a b imm rn rm rd alusrc ctr ctrl | mem rw/rd/res | wb rw/rd/res | expected {valid ctrl ctr rd aluA aluB st}
      vecs[0] = '{1'b1, 64'd10, 64'd20, 64'd0, 5'd2, 5'd3, 5'd1, 1'b0, 4'd2, 4'h8,
                  1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0,
                  '{1'b1, 4'h8, 4'd2, 5'd1, 64'd10, 64'd20, 64'd20}};
      vecs[1] = '{1'b1, 64'd0, 64'd2, 64'd0, 5'd1, 5'd3, 5'd2, 1'b0, 4'd6, 4'h8,
                  1'b1, 5'd1, 64'd5, 1'b0, 5'd0, 64'd0,
                  '{1'b1, 4'h8, 4'd6, 5'd2, 64'd5, 64'd2, 64'd2}};
      vecs[2] = '{1'b1, 64'd1, 64'd3, 64'd0, 5'd4, 5'd0, 5'd9, 1'b0, 4'd2, 4'h8,
                  1'b1, 5'd4, 64'd7, 1'b1, 5'd4, 64'd9,
                  '{1'b1, 4'h8, 4'd2, 5'd9, 64'd7, 64'd3, 64'd3}};
      vecs[3] = '{1'b1, 64'd11, 64'd12, 64'd0, 5'd5, 5'd6, 5'd10, 1'b0, 4'd1, 4'h8,
                  1'b1, 5'd7, 64'd100, 1'b1, 5'd6, 64'd200,
                  '{1'b1, 4'h8, 4'd1, 5'd10, 64'd11, 64'd200, 64'd200}};
      vecs[4] = '{1'b1, 64'd13, 64'd14, 64'hFFFF_FFFF_FFFF_FFF8, 5'd5, 5'd6, 5'd11, 1'b1, 4'd2, 4'h8,
                  1'b1, 5'd7, 64'd100, 1'b1, 5'd6, 64'd200,
                  '{1'b1, 4'h8, 4'd2, 5'd11, 64'd13, 64'hFFFF_FFFF_FFFF_FFF8, 64'd200}};
      vecs[5] = '{1'b1, 64'd0, 64'd0, 64'd0, 5'd31, 5'd31, 5'd0, 1'b0, 4'd2, 4'h2,
                  1'b1, 5'd31, 64'd55, 1'b1, 5'd31, 64'd66,
                  '{1'b1, 4'h2, 4'd2, 5'd0, 64'd0, 64'd0, 64'd0}};
      vecs[6] = '{1'b0, 64'd3, 64'd4, 64'd0, 5'd8, 5'd9, 5'd13, 1'b0, 4'd2, 4'h8,
                  1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0,
                  '{1'b0, 4'h0, 4'd0, 5'd0, 64'd0, 64'd0, 64'd0}};
      vecs[7] = '{1'b1, 64'd77, 64'd5, 64'd0, 5'd8, 5'd9, 5'd14, 1'b0, 4'd2, 4'h8,
                  1'b0, 5'd8, 64'd1, 1'b0, 5'd9, 64'd2,
                  '{1'b1, 4'h8, 4'd2, 5'd14, 64'd77, 64'd5, 64'd5}};
      vecs[8] = '{1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 64'd0, 5'd20, 5'd21, 5'd15, 1'b0, 4'd12, 4'h8,
                  1'b1, 5'd21, 64'hDEAD_BEEF_0000_0001, 1'b1, 5'd20, 64'h1234,
                  '{1'b1, 4'h8, 4'd12, 5'd15, 64'h1234, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001}};

      // Reset held two cycles under random inputs
      rst_n = 1'b0;
      randomInputs();
      step();
      randomInputs();
      step();
      checkResetState("reset");
      expStallCnt = 0;
      expFlushCnt = 0;
      checkPerf("reset");
      rst_n = 1'b1;
      quietInputs();

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i]);
         step();
         checkOutput($sformatf("vec%0d", i));
         checkField($sformatf("vec%0d.stall", i), {63'd0, stall_o}, 64'd0);
      end
      quietInputs();

      // Hold freezes everything, including over a concurrent flush; then a flush empties the stage
      driveId(5'd2, 5'd3, 5'd7, 64'h111, 64'h222, 64'd0, 1'b0, 4'd2, 4'h8);
      frozen = '{1'b1, 4'h8, 4'd2, 5'd7, 64'h111, 64'h222, 64'h222};
      scoreboard.push_back(frozen);
      step();
      checkOutput("holdLoad");
      for (int i = 0; i < 3; i++) begin
         hold = 1'b1;
         flush = (i == 1);
         driveId(5'd1, 5'd2, 5'(i + 16), {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 1'b0, 4'd6, 4'h8);
         scoreboard.push_back(frozen);
         step();
         checkOutput($sformatf("hold%0d", i));
      end
      hold = 1'b0;
      flush = 1'b1;
      scoreboard.push_back('{1'b0, 4'h0, 4'd0, 5'd0, 64'd0, 64'd0, 64'd0});
      step();
      expFlushCnt++;
      checkOutput("flushAfterHold");
      checkPerf("flushAfterHold");
      flush = 1'b0;

      // Load-use: LDUR X5 then ADD X6,X5,X5 stalls once, bubbles, then issues with WB forwarding
      driveId(5'd1, 5'd31, 5'd5, 64'h1000, 64'd0, 64'd8, 1'b1, 4'd2, 4'hC);
      scoreboard.push_back('{1'b1, 4'hC, 4'd2, 5'd5, 64'h1000, 64'd8, 64'd0});
      step();
      checkOutput("ldur");
      driveId(5'd5, 5'd5, 5'd6, 64'd0, 64'd0, 64'd0, 1'b0, 4'd2, 4'h8);
      #1;
      checkField("loadUse.stall", {63'd0, stall_o}, 64'd1);
      scoreboard.push_back('{1'b0, 4'h0, 4'd0, 5'd0, 64'd0, 64'd0, 64'd0});
      step();
      expStallCnt++;
      checkOutput("loadUse.bubble");
      checkField("loadUse.stallGone", {63'd0, stall_o}, 64'd0);
      wb_regwrite = 1'b1; wb_rd = 5'd5; wb_result = 64'd42;
      scoreboard.push_back('{1'b1, 4'h8, 4'd2, 5'd6, 64'd42, 64'd42, 64'd42});
      step();
      checkOutput("loadUse.add");
      checkField("loadUse.noRestall", {63'd0, stall_o}, 64'd0);
      quietInputs();

      // Flush and stall together: flush wins, stall still requested
      driveId(5'd2, 5'd3, 5'd9, 64'd1, 64'd2, 64'd16, 1'b1, 4'd2, 4'hC);
      scoreboard.push_back('{1'b1, 4'hC, 4'd2, 5'd9, 64'd1, 64'd16, 64'd2});
      step();
      checkOutput("ldur9");
      driveId(5'd4, 5'd9, 5'd10, 64'd0, 64'd0, 64'd0, 1'b0, 4'd2, 4'h8);
      flush = 1'b1;
      #1;
      checkField("flushStall.stall", {63'd0, stall_o}, 64'd1);
      scoreboard.push_back('{1'b0, 4'h0, 4'd0, 5'd0, 64'd0, 64'd0, 64'd0});
      step();
      expStallCnt++;
      expFlushCnt++;
      checkOutput("flushStall.bubble");
      checkPerf("flushStall");
      quietInputs();

      // A load to XZR never creates a hazard, and XZR is never forwarded
      driveId(5'd1, 5'd2, 5'd31, 64'd3, 64'd4, 64'd0, 1'b1, 4'd2, 4'hC);
      scoreboard.push_back('{1'b1, 4'hC, 4'd2, 5'd31, 64'd3, 64'd0, 64'd4});
      step();
      checkOutput("ldurXzr");
      driveId(5'd31, 5'd31, 5'd3, 64'd0, 64'd0, 64'd0, 1'b0, 4'd2, 4'h8);
      mem_regwrite = 1'b1; mem_rd = 5'd31; mem_result = 64'hBAD;
      #1;
      checkField("xzr.stall", {63'd0, stall_o}, 64'd0);
      scoreboard.push_back('{1'b1, 4'h8, 4'd2, 5'd3, 64'd0, 64'd0, 64'd0});
      step();
      checkOutput("xzr.add");

      // Reset in the middle of a valid instruction; rd/rn=0 would otherwise pick up forwarded data
      randomInputs();
      rst_n = 1'b0;
      step();
      checkResetState("midReset");
      expStallCnt = 0;
      expFlushCnt = 0;
      checkPerf("midReset");
      rst_n = 1'b1;
      quietInputs();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
